muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M multiply/divide sequencer (shift-add multiply, restoring divide)
//
// Ports:
//   clk     : clock, all state updates on rising edge
//   rst     : synchronous active-high reset
//   start   : begin an operation (sampled only when idle)
//   funct3  : RV32M operation select (MUL..REMU)
//   rs1     : operand A (multiplicand / dividend)
//   rs2     : operand B (multiplier / divisor)
//   busy    : high whenever not idle
//   done    : one-cycle pulse, result valid in that cycle
//   result  : final value, held until the next accepted start
//   stall   : pipeline hold request, (start & idle) | (busy & ~done)

module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state;
    logic [5:0]        cnt;
    logic [2:0]        f3_q;
    logic              neg_a_q;
    logic              neg_b_q;
    // Multiply: prod = {partial high, remaining multiplier bits}.
    // Divide:   prod = {partial remainder, dividend bits shifting into quotient}.
    logic [2*XLEN-1:0] prod;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [XLEN-1:0]   opnd;

    // Operand decode on the raw request (used only at accept).
    logic              signed_a;
    logic              signed_b;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   abs_a;
    logic [XLEN-1:0]   abs_b;
    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   bypass_val;

    // Unsigned forms are MULHU (011), DIVU (101) and REMU (111); MULHSU keeps rs1 signed only.
    assign signed_a   = !(funct3[0] && (funct3[1] || funct3[2]));
    assign signed_b   = signed_a && (funct3 != 3'b010);
    assign neg_a      = signed_a && rs1[XLEN-1];
    assign neg_b      = signed_b && rs2[XLEN-1];
    assign abs_a      = neg_a ? (~rs1 + 1'b1) : rs1;
    assign abs_b      = neg_b ? (~rs2 + 1'b1) : rs2;
    assign div_zero   = funct3[2] && (rs2 == '0);
    assign div_ovf    = funct3[2] && !funct3[0] &&
                        (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU.
    assign bypass_val = div_zero ? (funct3[1] ? rs1 : '1)
                                 : (funct3[1] ? '0  : {1'b1, {(XLEN-1){1'b0}}});

    // One iteration step of each algorithm.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;

    assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    // Shift next dividend bit into the remainder and try subtracting the divisor;
    // bit XLEN set means the trial went negative and the remainder is restored.
    assign div_trial = {prod[2*XLEN-1:XLEN], prod[XLEN-1]} - {1'b0, opnd};

    // Sign correction and word select for the FIX cycle.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_val;

    assign prod_fix = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
    assign quo_fix  = (neg_a_q ^ neg_b_q) ? (~prod[XLEN-1:0] + 1'b1) : prod[XLEN-1:0];
    assign rem_fix  = neg_a_q ? (~prod[2*XLEN-1:XLEN] + 1'b1) : prod[2*XLEN-1:XLEN];

    always_comb begin
        fix_val = '0;
        case (f3_q)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = quo_fix;
            default:                fix_val = rem_fix;
        endcase
    end

    assign stall = (start && (state == S_IDLE)) || (busy && !done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            f3_q    <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            prod    <= '0;
            opnd    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        f3_q    <= funct3;
                        neg_a_q <= neg_a;
                        neg_b_q <= neg_b;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        if (funct3[2]) begin
                            prod <= {{XLEN{1'b0}}, abs_a};
                            opnd <= abs_b;
                        end else begin
                            prod <= {{XLEN{1'b0}}, abs_b};
                            opnd <= abs_a;
                        end
                        if (div_zero || div_ovf) begin
                            result <= bypass_val;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else if (funct3[2]) begin
                            state  <= S_DIV;
                        end else begin
                            state  <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    // Add multiplicand when the current multiplier LSB is set, then shift right.
                    prod <= {mul_sum, prod[XLEN-1:1]};
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'(XLEN - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_DIV: begin
                    if (!div_trial[XLEN]) begin
                        prod <= {div_trial[XLEN-1:0], prod[XLEN-2:0], 1'b1};
                    end else begin
                        prod <= {prod[2*XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(XLEN - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result <= fix_val;
                    done   <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard testbench for muldiv_sequencer

module tb_muldiv_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        stall;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: RV32M semantics in plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [63:0]        p;
        logic               ovf;
        logic [31:0]        r;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sbv; r = p[63:32]; end
            3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = 32'd0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0)) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the scoreboard whenever done is seen, flags late or unexpected pulses.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc));
                check("result", result, e.res);
            end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_missing: got no done expected done at cycle %0d (now %0d)",
                     sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
    end

    // Issue one operation and watch stall/busy over its lifetime. junk_at>0 drives a
    // start with unrelated operands in that cycle offset; it must be ignored.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int junk_at);
        int          lat;
        logic [31:0] r;
        exp_t        e;
        lat = ref_lat(f, a, b);
        r   = ref_result(f, a, b);
        @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        e.res  = r;
        e.cyc  = cyc + lat;
        sb.push_back(e);
        #1;
        check("stall_accept", {31'd0, stall}, 32'd1);
        check("busy_accept", {31'd0, busy}, 32'd0);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            start = (k == junk_at);
            if (k == junk_at) begin
                funct3 = 3'($urandom);
                rs1    = $urandom;
                rs2    = $urandom;
            end
            #1;
            check("stall", {31'd0, stall}, {31'd0, (k < lat)});
            check("busy", {31'd0, busy}, {31'd0, (k <= lat)});
        end
        check("result_hold", result, r);
    endtask

    initial begin
        int   t0;
        exp_t e;
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        rs1    = '0;
        rs2    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;

        // Reference vectors with some ignored starts (mid-operation and in the done cycle).
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'h8000_0000, 32'd2, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 34);
        run_op(3'd5, 32'd100, 32'd0, 1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd7, 32'h1234_5678, 32'd0, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd0, 32'h1234_5678, 32'd0, 0);

        // Reset mid-operation abandons it; a fresh start afterwards completes normally.
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd5;
        rs1    = 32'd100;
        rs2    = 32'd7;
        t0     = cyc;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_cycle", 32'(cyc), 32'(t0 + 11));
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd5;
        rs1    = 32'd100;
        rs2    = 32'd7;
        e.res  = ref_result(3'd5, 32'd100, 32'd7);
        e.cyc  = t0 + 46;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Back-to-back: start held high yields one done every 35 cycles.
        @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd1;
        rs1    = 32'hDEAD_BEEF;
        rs2    = 32'h0BAD_F00D;
        t0     = cyc;
        for (int i = 0; i < 3; i++) begin
            e.res = ref_result(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
            e.cyc = t0 + 35 * i + 34;
            sb.push_back(e);
        end
        repeat (105) @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [31:0] a;
            logic [31:0] b;
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 34)) : 0);
        end

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
